// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access engine.
// Holds the MemReadType encodings, the bus size codes, the FSM state type
// and the helpers that decode size and alignment from the decode-stage controls.
package mem_access_unit_pkg;

   // MemReadType: bit2 = sign-extend, bits1:0 = access size
   localparam logic [2:0] MRT_B    = 3'b100;
   localparam logic [2:0] MRT_BU   = 3'b000;
   localparam logic [2:0] MRT_H    = 3'b101;
   localparam logic [2:0] MRT_HU   = 3'b001;
   localparam logic [2:0] MRT_W    = 3'b010;
   localparam logic [2:0] MRT_NONE = 3'b111;

   // Bus data_size codes
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Size field 11 ("none") is treated as a full word.
   function automatic logic [1:0] mrt_to_size(input logic [2:0] mrt);
      case (mrt[1:0])
         2'b00:   mrt_to_size = SZ_BYTE;
         2'b01:   mrt_to_size = SZ_HALF;
         default: mrt_to_size = SZ_WORD;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: is_misaligned = 1'b0;
         SZ_HALF: is_misaligned = addr_lo[0];
         default: is_misaligned = (addr_lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: little-endian load extraction.
// Ports:
//   rdata   - raw 32-bit bus read data
//   addr_lo - low two address bits selecting the byte/half lane
//   size    - bus size code (byte / half / word)
//   sign    - 1 = sign-extend, 0 = zero-extend (ignored for word)
//   result  - extended 32-bit load value
module load_align
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_v = rdata[7:0];
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         default: byte_v = rdata[31:24];
      endcase
      half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (size)
         SZ_BYTE: result = {{24{sign & byte_v[7]}}, byte_v};
         SZ_HALF: result = {{16{sign & half_v[15]}}, half_v};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access engine.
// Runs one SRAM-like bus transaction per load/store, checks alignment,
// replicates store data across byte lanes and extends load data.
// Ports:
//   clk, resetn                      - clock, async active-low reset
//   in_valid, MemReadM, MemWriteM,
//   MemReadTypeM, addrM, WriteDataM  - MEM-stage instruction controls
//   flushM                           - cancel the current MEM instruction
//   data_req/wr/size/addr/wdata      - bus request side
//   data_addr_ok/data_ok/rdata       - bus response side
//   mem_stall                        - hold the pipeline
//   load_data                        - extended load result (valid in DONE)
//   AdEL, AdES, BadVAddr             - misaligned-access exception outputs
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   input  logic                  MemReadM,
   input  logic                  MemWriteM,
   input  logic [2:0]            MemReadTypeM,
   input  logic [ADDR_WIDTH-1:0] addrM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   input  logic                  flushM,
   output logic                  data_req,
   output logic                  data_wr,
   output logic [1:0]            data_size,
   output logic [ADDR_WIDTH-1:0] data_addr,
   output logic [DATA_WIDTH-1:0] data_wdata,
   input  logic                  data_addr_ok,
   input  logic                  data_data_ok,
   input  logic [DATA_WIDTH-1:0] data_rdata,
   output logic                  mem_stall,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  AdEL,
   output logic                  AdES,
   output logic [ADDR_WIDTH-1:0] BadVAddr
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  wr_q, wr_d;
   logic [1:0]            size_q, size_d;
   logic                  sign_q, sign_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
   logic                  cancel_q, cancel_d;

   logic [1:0]            req_size;
   logic                  misaligned;
   logic                  idle;
   logic                  go;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [31:0]           aligned_rdata;

   // Request decode from the live MEM-stage controls
   always_comb begin
      req_size   = mrt_to_size(MemReadTypeM);
      misaligned = is_misaligned(req_size, addrM[1:0]);
      idle       = (state_q == ST_IDLE);
      go         = in_valid & (MemReadM | MemWriteM) & ~misaligned & ~flushM & idle;
      case (req_size)
         SZ_BYTE: req_wdata = {4{WriteDataM[7:0]}};
         SZ_HALF: req_wdata = {2{WriteDataM[15:0]}};
         default: req_wdata = WriteDataM;
      endcase
   end

   load_align u_load_align (
      .rdata   (data_rdata),
      .addr_lo (addr_q[1:0]),
      .size    (size_q),
      .sign    (sign_q),
      .result  (aligned_rdata)
   );

   // State register (and latched transaction fields)
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         wr_q        <= 1'b0;
         size_q      <= '0;
         sign_q      <= 1'b0;
         wdata_q     <= '0;
         load_data_q <= '0;
         cancel_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wr_q        <= wr_d;
         size_q      <= size_d;
         sign_q      <= sign_d;
         wdata_q     <= wdata_d;
         load_data_q <= load_data_d;
         cancel_q    <= cancel_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wr_d        = wr_q;
      size_d      = size_q;
      sign_d      = sign_q;
      wdata_d     = wdata_q;
      load_data_d = load_data_q;
      cancel_d    = cancel_q;

      case (state_q)
         ST_IDLE: begin
            if (go) begin
               state_d  = ST_REQ;
               addr_d   = addrM;
               wr_d     = MemWriteM;
               size_d   = req_size;
               sign_d   = MemReadTypeM[2];
               wdata_d  = req_wdata;
               cancel_d = 1'b0;
            end
         end
         ST_REQ: begin
            if (data_addr_ok) begin
               if (flushM) begin
                  // Accepted but cancelled: drain the response unless it
                  // already arrived in this same cycle.
                  if (data_data_ok) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d  = ST_WAIT;
                     cancel_d = 1'b1;
                  end
               end else if (data_data_ok) begin
                  state_d = ST_DONE;
                  if (!wr_q) load_data_d = aligned_rdata;
               end else begin
                  state_d = ST_WAIT;
               end
            end else if (flushM) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (flushM) cancel_d = 1'b1;
            if (data_data_ok) begin
               if (cancel_q | flushM) begin
                  state_d  = ST_IDLE;
                  cancel_d = 1'b0;
               end else begin
                  state_d = ST_DONE;
                  if (!wr_q) load_data_d = aligned_rdata;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      data_req   = (state_q == ST_REQ);
      data_wr    = wr_q;
      data_size  = size_q;
      data_addr  = addr_q;
      data_wdata = wdata_q;
      load_data  = load_data_q;
      mem_stall  = go | (state_q == ST_REQ) | (state_q == ST_WAIT);
      AdEL       = in_valid & MemReadM  & misaligned & idle;
      AdES       = in_valid & MemWriteM & misaligned & idle;
      BadVAddr   = addrM;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid, MemReadM, MemWriteM, flushM;
   logic [2:0]  MemReadTypeM;
   logic [31:0] addrM, WriteDataM;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_stall;
   logic [31:0] load_data;
   logic        AdEL, AdES;
   logic [31:0] BadVAddr;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .in_valid     (in_valid),
      .MemReadM     (MemReadM),
      .MemWriteM    (MemWriteM),
      .MemReadTypeM (MemReadTypeM),
      .addrM        (addrM),
      .WriteDataM   (WriteDataM),
      .flushM       (flushM),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .mem_stall    (mem_stall),
      .load_data    (load_data),
      .AdEL         (AdEL),
      .AdES         (AdES),
      .BadVAddr     (BadVAddr)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  mrt;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int unsigned aok_wait;   // REQ cycles with addr_ok low
      int unsigned dok_wait;   // WAIT cycles, data_ok in the last one
      logic [1:0]  exp_size;
      logic [31:0] exp_wdata;
      logic        exp_misal;
      logic [31:0] exp_load;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs [NVEC];

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] last_load;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pop_chk(input string name);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, got %h expected none", name, load_data);
      end else begin
         e = exp_q.pop_front();
         chk(name, load_data, e);
      end
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; flushM = 1'b0;
   endtask

   task automatic present(input logic rd, input logic wr, input logic [2:0] mrt,
                          input logic [31:0] addr, input logic [31:0] wd);
      in_valid = 1'b1; MemReadM = rd; MemWriteM = wr; MemReadTypeM = mrt;
      addrM = addr; WriteDataM = wd; flushM = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string       tag;
      int unsigned stall_cnt;
      logic [31:0] addr_at_req;
      tag = $sformatf("v%0d", idx);
      stall_cnt = 0;
      @(negedge clk);
      present(v.rd, v.wr, v.mrt, v.addr, v.wdata);
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      #1;
      chk({tag, "_AdEL"}, AdEL, v.rd & v.exp_misal);
      chk({tag, "_AdES"}, AdES, v.wr & v.exp_misal);
      if (v.exp_misal) begin
         chk({tag, "_BadVAddr"}, BadVAddr, v.addr);
         chk({tag, "_misal_stall"}, mem_stall, 1'b0);
         @(negedge clk);
         chk({tag, "_misal_noreq"}, data_req, 1'b0);
         idle_inputs();
      end else begin
         stall_cnt += mem_stall;
         exp_q.push_back(v.rd ? v.exp_load : last_load);
         if (v.rd) last_load = v.exp_load;
         @(negedge clk);
         chk({tag, "_req"}, data_req, 1'b1);
         chk({tag, "_addr"}, data_addr, v.addr);
         chk({tag, "_wr"}, data_wr, v.wr);
         chk({tag, "_size"}, data_size, v.exp_size);
         if (v.wr) chk({tag, "_wdata"}, data_wdata, v.exp_wdata);
         addr_at_req = data_addr;
         for (int unsigned i = 0; i < v.aok_wait; i++) begin
            stall_cnt += mem_stall;
            @(negedge clk);
            chk({tag, "_req_hold"}, data_req, 1'b1);
            chk({tag, "_addr_hold"}, data_addr, addr_at_req);
         end
         stall_cnt += mem_stall;
         data_addr_ok = 1'b1;
         if (v.dok_wait == 0) begin
            data_data_ok = 1'b1; data_rdata = v.rdata;
         end
         @(negedge clk);
         data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h5A5A_5A5A;
         for (int unsigned i = 1; i <= v.dok_wait; i++) begin
            chk({tag, "_wait_noreq"}, data_req, 1'b0);
            stall_cnt += mem_stall;
            if (i == v.dok_wait) begin
               data_data_ok = 1'b1; data_rdata = v.rdata;
            end
            @(negedge clk);
            data_data_ok = 1'b0; data_rdata = 32'h5A5A_5A5A;
         end
         // DONE cycle: inputs still live, must not stall
         #1;
         chk({tag, "_done_stall"}, mem_stall, 1'b0);
         chk({tag, "_stall_cycles"}, stall_cnt, 2 + v.aok_wait + v.dok_wait);
         pop_chk({tag, "_load"});
         idle_inputs();
         @(negedge clk);
         chk({tag, "_after_req"}, data_req, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //            rd    wr    mrt       addr          wdata         rdata        aw dw size     exp_wdata     mis  exp_load
      vecs[0]  = '{1'b1, 1'b0, MRT_B,    32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, SZ_BYTE, 32'h0,        1'b0, 32'hFFFF_FF80};
      vecs[1]  = '{1'b1, 1'b0, MRT_BU,   32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, SZ_BYTE, 32'h0,        1'b0, 32'h0000_0080};
      vecs[2]  = '{1'b0, 1'b1, MRT_H,    32'h0000_2002, 32'hDEAD_BEEF, 32'h0,        0, 3, SZ_HALF, 32'hBEEF_BEEF, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, 1'b0, MRT_W,    32'h0000_3001, 32'h0,        32'h0,         0, 0, SZ_WORD, 32'h0,        1'b1, 32'h0};
      vecs[4]  = '{1'b0, 1'b1, MRT_W,    32'h0000_3002, 32'h1111_2222, 32'h0,        0, 0, SZ_WORD, 32'h0,        1'b1, 32'h0};
      vecs[5]  = '{1'b1, 1'b0, MRT_W,    32'h0000_5000, 32'h0,        32'h1234_5678, 4, 0, SZ_WORD, 32'h0,        1'b0, 32'h1234_5678};
      vecs[6]  = '{1'b1, 1'b0, MRT_H,    32'h0000_4002, 32'h0,        32'h7FFF_0000, 0, 1, SZ_HALF, 32'h0,        1'b0, 32'h0000_7FFF};
      vecs[7]  = '{1'b1, 1'b0, MRT_H,    32'h0000_4000, 32'h0,        32'h7FFF_8001, 1, 2, SZ_HALF, 32'h0,        1'b0, 32'hFFFF_8001};
      vecs[8]  = '{1'b1, 1'b0, MRT_HU,   32'h0000_4000, 32'h0,        32'h7FFF_8001, 0, 0, SZ_HALF, 32'h0,        1'b0, 32'h0000_8001};
      vecs[9]  = '{1'b0, 1'b1, MRT_BU,   32'h0000_6001, 32'h0000_00A5, 32'h0,        2, 1, SZ_BYTE, 32'hA5A5_A5A5, 1'b0, 32'h0};
      vecs[10] = '{1'b0, 1'b1, MRT_W,    32'h0000_6004, 32'h1122_3344, 32'h0,        0, 0, SZ_WORD, 32'h1122_3344, 1'b0, 32'h0};
      vecs[11] = '{1'b1, 1'b0, MRT_B,    32'h0000_7001, 32'h0,        32'h0000_7F00, 0, 0, SZ_BYTE, 32'h0,        1'b0, 32'h0000_007F};
      vecs[12] = '{1'b1, 1'b0, MRT_BU,   32'h0000_7002, 32'h0,        32'h00AB_0000, 0, 0, SZ_BYTE, 32'h0,        1'b0, 32'h0000_00AB};
      vecs[13] = '{1'b1, 1'b0, MRT_H,    32'h0000_4001, 32'h0,        32'h0,         0, 0, SZ_HALF, 32'h0,        1'b1, 32'h0};
      vecs[14] = '{1'b1, 1'b0, MRT_NONE, 32'h0000_8000, 32'h0,        32'hCAFE_F00D, 1, 1, SZ_WORD, 32'h0,        1'b0, 32'hCAFE_F00D};
      vecs[15] = '{1'b1, 1'b0, MRT_NONE, 32'h0000_8002, 32'h0,        32'h0,         0, 0, SZ_WORD, 32'h0,        1'b1, 32'h0};
      vecs[16] = '{1'b1, 1'b0, MRT_B,    32'h0000_7000, 32'h0,        32'h0000_00FE, 0, 0, SZ_BYTE, 32'h0,        1'b0, 32'hFFFF_FFFE};
      vecs[17] = '{1'b0, 1'b1, MRT_HU,   32'h0000_2001, 32'h0000_BEEF, 32'h0,        0, 0, SZ_HALF, 32'h0,        1'b1, 32'h0};

      idle_inputs();
      MemReadTypeM = MRT_W; addrM = '0; WriteDataM = '0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
      resetn = 1'b1;
      last_load = '0;
      #2 resetn = 1'b0;
      #1;
      chk("rst_req",   data_req,   1'b0);
      chk("rst_wr",    data_wr,    1'b0);
      chk("rst_size",  data_size,  2'd0);
      chk("rst_addr",  data_addr,  32'h0);
      chk("rst_wdata", data_wdata, 32'h0);
      chk("rst_load",  load_data,  32'h0);
      chk("rst_stall", mem_stall,  1'b0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

      // flushM in WAIT: response drained, no DONE, next access waits
      @(negedge clk);
      present(1'b1, 1'b0, MRT_W, 32'h0000_9000, 32'h0);
      @(negedge clk);
      data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0;
      flushM = 1'b1;
      #1;
      chk("A_wait_req", data_req, 1'b0);
      chk("A_wait_stall", mem_stall, 1'b1);
      @(negedge clk);
      flushM = 1'b0; addrM = 32'h0000_A000;
      #1;
      chk("A_drain_stall", mem_stall, 1'b1);
      chk("A_drain_noreq", data_req, 1'b0);
      data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      data_data_ok = 1'b0;
      #1;
      chk("A_no_done", mem_stall, 1'b1);
      chk("A_noreq_yet", data_req, 1'b0);
      chk("A_load_kept", load_data, last_load);
      exp_q.push_back(32'h0A0A_0A0A);
      last_load = 32'h0A0A_0A0A;
      @(negedge clk);
      chk("A_new_req", data_req, 1'b1);
      chk("A_new_addr", data_addr, 32'h0000_A000);
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0A0A_0A0A;
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      #1;
      chk("A_done_stall", mem_stall, 1'b0);
      pop_chk("A_new_load");
      idle_inputs();

      // flushM in REQ before addr_ok: request withdrawn next cycle
      @(negedge clk);
      present(1'b1, 1'b0, MRT_W, 32'h0000_B000, 32'h0);
      @(negedge clk);
      chk("B_req", data_req, 1'b1);
      flushM = 1'b1;
      @(negedge clk);
      idle_inputs();
      #1;
      chk("B_req_dropped", data_req, 1'b0);
      chk("B_stall", mem_stall, 1'b0);
      chk("B_load_kept", load_data, last_load);

      // flushM together with addr_ok: cancelled WAIT, data discarded
      @(negedge clk);
      present(1'b1, 1'b0, MRT_W, 32'h0000_C000, 32'h0);
      @(negedge clk);
      data_addr_ok = 1'b1; flushM = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0;
      idle_inputs();
      #1;
      chk("C_wait_req", data_req, 1'b0);
      chk("C_wait_stall", mem_stall, 1'b1);
      data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      data_data_ok = 1'b0;
      #1;
      chk("C_idle_stall", mem_stall, 1'b0);
      chk("C_discard", load_data, last_load);

      // resetn pulsed in WAIT: immediate return to idle outputs
      @(negedge clk);
      present(1'b1, 1'b0, MRT_W, 32'h0000_D004, 32'h0);
      @(negedge clk);
      data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0;
      idle_inputs();
      #1;
      chk("D_wait_stall", mem_stall, 1'b1);
      resetn = 1'b0;
      #1;
      chk("D_rst_req", data_req, 1'b0);
      chk("D_rst_stall", mem_stall, 1'b0);
      chk("D_rst_load", load_data, 32'h0);
      chk("D_rst_addr", data_addr, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      last_load = '0;
      @(negedge clk);
      chk("D_idle_stall", mem_stall, 1'b0);
      run_vec(vecs[1], 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
